reorder_buffer: RTL and testbench
=================================

REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of ROB entries; power of two.
REQ-002 SHALL have parameter PREG_W, default 6, physical register index width.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port alloc_valid  input  1  rename presents an instruction.
REQ-006 SHALL have port alloc_ready  output  1  entry available (not full).
REQ-007 SHALL have port alloc_rd_write  input  1  instruction writes rd.
REQ-008 SHALL have ports alloc_rd_p_new and alloc_rd_p_old  input  PREG_W  new and previous mapping of rd.
REQ-009 SHALL have port alloc_pc  input  32  instruction PC.
REQ-010 SHALL have port alloc_tag  output  log2(DEPTH)  index of the entry allocated this cycle; equals the tail index.
REQ-011 SHALL have ports wb_valid  input  1 and wb_tag  input  log2(DEPTH)  execution-complete notification.
REQ-012 SHALL have port flush  input  1  discard all in-flight entries.
REQ-013 SHALL have ports commit_valid  output  1, commit_pc  output  32, commit_rd_write  output  1, commit_rd_p_old  output  PREG_W, commit_rd_p_new  output  PREG_W  retirement record; p_old returns to the free list.
REQ-014 SHALL have ports empty  output  1 and full  output  1.

Function
REQ-015 SHALL be a circular buffer with head/tail pointers of log2(DEPTH)+1 bits, the MSB being the wrap bit.
REQ-016 SHALL assert full when head and tail indices are equal and wrap bits differ, and empty when pointers are fully equal; both derive from registered state only.
REQ-017 SHALL drive alloc_ready = !full, combinationally.
REQ-018 SHALL accept an allocation on an edge where alloc_valid && alloc_ready: write pc, rd_write, p_new and p_old at tail, set valid=1 and done=0, increment tail.
REQ-019 SHALL set done of entry wb_tag on an edge with wb_valid if that entry is valid; writeback to an invalid entry SHALL be ignored.
REQ-020 SHALL retire the head entry on an edge where it is valid and done: register its fields onto commit_* with commit_valid=1 for one cycle, clear its valid bit, and increment head; otherwise commit_valid=0.
REQ-021 SHALL retire at most one entry per cycle, in order; commit has no back-pressure.
REQ-022 SHALL cause a writeback at edge N to the head entry to appear as commit_valid in the cycle after edge N+1.
REQ-023 SHALL allow allocate, writeback and commit on the same edge; a full ROB SHALL NOT accept allocation even if a commit occurs that edge (no bypass).
REQ-024 SHALL, on flush at an edge, clear all valid and done bits, set head=tail=0, drive commit_valid=0 next cycle, and ignore that cycle's alloc and wb; flush has highest priority.
REQ-025 SHALL wrap pointers from DEPTH-1 to 0, toggling the wrap bit.
REQ-026 SHALL pass commit_rd_write unchanged; when it is 0, commit_rd_p_old/new carry stored values and the consumer ignores them.

Reset
REQ-027 SHALL, while rst_n=0, clear all valid/done bits, set head=tail=0, and drive commit_valid=0, commit_pc=0, commit_rd_write=0, commit_rd_p_old=0, commit_rd_p_new=0, empty=1, full=0, alloc_ready=1.
REQ-028 SHALL discard in-flight entries on reset asserted mid-operation and resume on the first edge after deassertion.

Structure
REQ-029 SHALL take DEPTH, PREG_W, the tag width and an entry typedef rob_entry_t (valid, done, rd_write, p_new, p_old, pc) from shared package core_pkg.
REQ-030 SHALL use one sub-module, rob_ptr: a wrap-bit pointer with increment and clear.

Verification
REQ-031 SHALL cover: alloc pc=0x100 p_new=33 p_old=5 tag 0, wb tag 0 -> commit_valid with pc=0x100, p_old=5 two edges after wb.
REQ-032 SHALL cover: alloc tags 0,1,2, wb order 2,0,1 -> commits in pc order 0,1,2, one per cycle, tag 0 commit following wb of 0.
REQ-033 SHALL cover: 16 allocs, no wb -> full=1, alloc_ready=0, 17th alloc dropped; wb tag 0 -> one commit, then alloc accepted with tag 0, wrap bit toggled.
REQ-034 SHALL cover: 5 entries, tags 1,3 done, flush -> empty=1 next cycle, no commits, next alloc gets tag 0.
REQ-035 SHALL cover: wb to invalid tag 7 on an empty ROB -> no state change, commit_valid stays 0.
REQ-036 SHALL cover: rst_n low with 4 entries mid-flight -> all outputs at reset values immediately (asynchronous).

Source files
------------

// File: rtl/core_pkg.sv
// core_pkg: sizing constants and the per-entry record shared by the reorder buffer files.
package core_pkg;

    localparam int ROB_DEPTH  = 16;
    localparam int ROB_PREG_W = 6;
    localparam int ROB_TAG_W  = $clog2(ROB_DEPTH);

    // One in-flight instruction. valid marks an occupied slot; done marks that
    // execution has written back, so the slot may retire once it reaches the head.
    typedef struct packed {
        logic                  valid;
        logic                  done;
        logic                  rd_write;
        logic [ROB_PREG_W-1:0] p_new;
        logic [ROB_PREG_W-1:0] p_old;
        logic [31:0]           pc;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_if.sv
// reorder_buffer_if: allocation, writeback, flush and commit signals of the reorder buffer.
// The master side is rename/execute/retire logic; the slave side is the buffer itself.
interface reorder_buffer_if #(
    parameter int DEPTH  = core_pkg::ROB_DEPTH,
    parameter int PREG_W = core_pkg::ROB_PREG_W
);

    localparam int TAG_W = $clog2(DEPTH);

    // Allocation from rename
    logic              alloc_valid;
    logic              alloc_ready;
    logic              alloc_rd_write;
    logic [PREG_W-1:0] alloc_rd_p_new;
    logic [PREG_W-1:0] alloc_rd_p_old;
    logic [31:0]       alloc_pc;
    logic [TAG_W-1:0]  alloc_tag;

    // Execution-complete notification
    logic              wb_valid;
    logic [TAG_W-1:0]  wb_tag;

    // Pipeline flush
    logic              flush;

    // Retirement record
    logic              commit_valid;
    logic [31:0]       commit_pc;
    logic              commit_rd_write;
    logic [PREG_W-1:0] commit_rd_p_old;
    logic [PREG_W-1:0] commit_rd_p_new;

    // Occupancy
    logic              empty;
    logic              full;

    modport master (
        output alloc_valid, alloc_rd_write, alloc_rd_p_new, alloc_rd_p_old, alloc_pc,
        output wb_valid, wb_tag, flush,
        input  alloc_ready, alloc_tag,
        input  commit_valid, commit_pc, commit_rd_write, commit_rd_p_old, commit_rd_p_new,
        input  empty, full
    );

    modport slave (
        input  alloc_valid, alloc_rd_write, alloc_rd_p_new, alloc_rd_p_old, alloc_pc,
        input  wb_valid, wb_tag, flush,
        output alloc_ready, alloc_tag,
        output commit_valid, commit_pc, commit_rd_write, commit_rd_p_old, commit_rd_p_new,
        output empty, full
    );

endinterface

// File: rtl/rob_ptr.sv
// rob_ptr: circular-buffer pointer with an extra wrap bit above the index.
// Because DEPTH is a power of two, a plain increment wraps the index from
// DEPTH-1 to 0 and toggles the wrap bit in one step.
module rob_ptr #(
    parameter int DEPTH = core_pkg::ROB_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr_i,
    input  logic                   inc_i,
    output logic [$clog2(DEPTH):0] ptr_o
);

    localparam int PTR_W = $clog2(DEPTH) + 1;

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    // Clear wins over increment so a flush always lands on slot 0.
    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = ptr_q + PTR_W'(1);
        end
    end

    // Pointer register, returned to slot 0 with a clear wrap bit on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order retirement queue. Rename allocates at the tail,
// execution marks entries done by tag, and the head retires one entry per
// cycle once it is done, returning p_old to the free list via the commit record.
module reorder_buffer
    import core_pkg::*;
#(
    parameter int DEPTH  = ROB_DEPTH,
    parameter int PREG_W = ROB_PREG_W
) (
    input  logic            clk,
    input  logic            rst_n,
    reorder_buffer_if.slave rob
);

    // Tag width follows the package for the standard depth and is derived
    // from DEPTH whenever the buffer is resized.
    localparam int TAG_W = (DEPTH == ROB_DEPTH) ? ROB_TAG_W : $clog2(DEPTH);
    localparam int PTR_W = TAG_W + 1;

    rob_entry_t        entries_q [DEPTH];
    rob_entry_t        entries_d [DEPTH];

    logic [PTR_W-1:0]  head_ptr;
    logic [PTR_W-1:0]  tail_ptr;
    logic [TAG_W-1:0]  head_idx;
    logic [TAG_W-1:0]  tail_idx;
    rob_entry_t        head_entry;

    logic              empty;
    logic              full;
    logic              alloc_fire;
    logic              wb_hit;
    logic              retire;

    logic              commit_valid_q;
    logic              commit_valid_d;
    logic [31:0]       commit_pc_q;
    logic [31:0]       commit_pc_d;
    logic              commit_rd_write_q;
    logic              commit_rd_write_d;
    logic [PREG_W-1:0] commit_rd_p_old_q;
    logic [PREG_W-1:0] commit_rd_p_old_d;
    logic [PREG_W-1:0] commit_rd_p_new_q;
    logic [PREG_W-1:0] commit_rd_p_new_d;

    // Occupancy and handshake decode, derived only from registered state.
    // Full means the indices meet with opposite wrap bits; empty means the
    // pointers match exactly. A full buffer never takes an allocation, even
    // on an edge where the head retires.
    always_comb begin
        head_idx   = head_ptr[TAG_W-1:0];
        tail_idx   = tail_ptr[TAG_W-1:0];
        head_entry = entries_q[head_idx];
        empty      = (head_ptr == tail_ptr);
        full       = (head_idx == tail_idx) && (head_ptr[TAG_W] != tail_ptr[TAG_W]);
        alloc_fire = rob.alloc_valid && !full && !rob.flush;
        wb_hit     = rob.wb_valid && entries_q[rob.wb_tag].valid && !rob.flush;
        retire     = head_entry.valid && head_entry.done && !rob.flush;
    end

    // Entry array next state. Flush clears every slot and suppresses all
    // other updates. Writeback is applied before retirement so a retiring
    // slot always leaves with done cleared, and allocation last since it can
    // only target the head slot when nothing is retiring there.
    always_comb begin
        entries_d = entries_q;
        if (rob.flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_d[i].valid = 1'b0;
                entries_d[i].done  = 1'b0;
            end
        end else begin
            if (wb_hit) begin
                entries_d[rob.wb_tag].done = 1'b1;
            end
            if (retire) begin
                entries_d[head_idx].valid = 1'b0;
                entries_d[head_idx].done  = 1'b0;
            end
            if (alloc_fire) begin
                entries_d[tail_idx].valid    = 1'b1;
                entries_d[tail_idx].done     = 1'b0;
                entries_d[tail_idx].rd_write = rob.alloc_rd_write;
                entries_d[tail_idx].p_new    = rob.alloc_rd_p_new;
                entries_d[tail_idx].p_old    = rob.alloc_rd_p_old;
                entries_d[tail_idx].pc       = rob.alloc_pc;
            end
        end
    end

    // Entry storage; reset empties every slot immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            entries_q <= entries_d;
        end
    end

    // Head advances on retirement, tail on an accepted allocation; flush
    // returns both to slot 0.
    rob_ptr #(
        .DEPTH (DEPTH)
    ) u_head_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (rob.flush),
        .inc_i (retire),
        .ptr_o (head_ptr)
    );

    rob_ptr #(
        .DEPTH (DEPTH)
    ) u_tail_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (rob.flush),
        .inc_i (alloc_fire),
        .ptr_o (tail_ptr)
    );

    // Commit record next state: load the head fields when it retires,
    // otherwise drop commit_valid and leave the payload as it was.
    always_comb begin
        commit_valid_d    = 1'b0;
        commit_pc_d       = commit_pc_q;
        commit_rd_write_d = commit_rd_write_q;
        commit_rd_p_old_d = commit_rd_p_old_q;
        commit_rd_p_new_d = commit_rd_p_new_q;
        if (retire) begin
            commit_valid_d    = 1'b1;
            commit_pc_d       = head_entry.pc;
            commit_rd_write_d = head_entry.rd_write;
            commit_rd_p_old_d = head_entry.p_old;
            commit_rd_p_new_d = head_entry.p_new;
        end
    end

    // Commit record register, held for exactly one cycle per retirement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            commit_valid_q    <= 1'b0;
            commit_pc_q       <= '0;
            commit_rd_write_q <= 1'b0;
            commit_rd_p_old_q <= '0;
            commit_rd_p_new_q <= '0;
        end else begin
            commit_valid_q    <= commit_valid_d;
            commit_pc_q       <= commit_pc_d;
            commit_rd_write_q <= commit_rd_write_d;
            commit_rd_p_old_q <= commit_rd_p_old_d;
            commit_rd_p_new_q <= commit_rd_p_new_d;
        end
    end

    assign rob.alloc_ready     = !full;
    assign rob.alloc_tag       = tail_idx;
    assign rob.empty           = empty;
    assign rob.full            = full;
    assign rob.commit_valid    = commit_valid_q;
    assign rob.commit_pc       = commit_pc_q;
    assign rob.commit_rd_write = commit_rd_write_q;
    assign rob.commit_rd_p_old = commit_rd_p_old_q;
    assign rob.commit_rd_p_new = commit_rd_p_new_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed scenarios for the reorder buffer. Expected
// commit records are queued when allocations are issued and a monitor pops
// and compares them whenever the buffer presents commit_valid.
`timescale 1ns/1ps
module tb_reorder_buffer;

    localparam int DEPTH  = 16;
    localparam int PREG_W = 6;
    localparam int TAG_W  = 4;

    typedef struct {
        logic [31:0]       pc;
        logic              rd_write;
        logic [PREG_W-1:0] p_old;
        logic [PREG_W-1:0] p_new;
    } commit_t;

    logic    clk   = 1'b0;
    logic    rst_n = 1'b0;
    commit_t expQ[$];
    int      numChecks = 0;
    int      numFails  = 0;

    reorder_buffer_if #(.DEPTH(DEPTH), .PREG_W(PREG_W)) bus ();

    reorder_buffer #(
        .DEPTH  (DEPTH),
        .PREG_W (PREG_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rob   (bus)
    );

    // Free-running clock, rising edges at 5, 15, 25 ns ...
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        numChecks++;
        if (actual !== expected) begin
            numFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic setIdle();
        bus.alloc_valid    = 1'b0;
        bus.alloc_rd_write = 1'b0;
        bus.alloc_rd_p_new = '0;
        bus.alloc_rd_p_old = '0;
        bus.alloc_pc       = '0;
        bus.wb_valid       = 1'b0;
        bus.wb_tag         = '0;
        bus.flush          = 1'b0;
    endtask

    // Drives one cycle of inputs just after a falling edge, lets one rising
    // edge sample them, and returns at the next falling edge with inputs idle.
    task automatic applyStimulus(input logic av, input logic [31:0] pc, input logic rdw,
                                 input logic [PREG_W-1:0] pnew, input logic [PREG_W-1:0] pold,
                                 input logic wv, input logic [TAG_W-1:0] wtag, input logic fl);
        bus.alloc_valid    = av;
        bus.alloc_pc       = pc;
        bus.alloc_rd_write = rdw;
        bus.alloc_rd_p_new = pnew;
        bus.alloc_rd_p_old = pold;
        bus.wb_valid       = wv;
        bus.wb_tag         = wtag;
        bus.flush          = fl;
        @(posedge clk);
        @(negedge clk);
        setIdle();
    endtask

    task automatic pushExpected(input logic [31:0] pc, input logic rdw,
                                input logic [PREG_W-1:0] pnew, input logic [PREG_W-1:0] pold);
        commit_t e;
        e.pc       = pc;
        e.rd_write = rdw;
        e.p_new    = pnew;
        e.p_old    = pold;
        expQ.push_back(e);
    endtask

    task automatic doAlloc(input logic [31:0] pc, input logic rdw, input logic [PREG_W-1:0] pnew,
                           input logic [PREG_W-1:0] pold, input bit expectAccept);
        if (expectAccept) pushExpected(pc, rdw, pnew, pold);
        applyStimulus(1'b1, pc, rdw, pnew, pold, 1'b0, '0, 1'b0);
    endtask

    task automatic doAllocWb(input logic [31:0] pc, input logic rdw, input logic [PREG_W-1:0] pnew,
                             input logic [PREG_W-1:0] pold, input logic [TAG_W-1:0] wtag);
        pushExpected(pc, rdw, pnew, pold);
        applyStimulus(1'b1, pc, rdw, pnew, pold, 1'b1, wtag, 1'b0);
    endtask

    task automatic doWb(input logic [TAG_W-1:0] wtag);
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1, wtag, 1'b0);
    endtask

    task automatic doIdle();
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic doFlush();
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0, '0, 1'b1);
        expQ.delete();
    endtask

    task automatic checkResetOutputs(input string pfx);
        checkOutput({pfx, "_commit_valid"}, 32'(bus.commit_valid), 0);
        checkOutput({pfx, "_commit_pc"}, bus.commit_pc, 0);
        checkOutput({pfx, "_commit_rd_write"}, 32'(bus.commit_rd_write), 0);
        checkOutput({pfx, "_commit_p_old"}, 32'(bus.commit_rd_p_old), 0);
        checkOutput({pfx, "_commit_p_new"}, 32'(bus.commit_rd_p_new), 0);
        checkOutput({pfx, "_empty"}, 32'(bus.empty), 1);
        checkOutput({pfx, "_full"}, 32'(bus.full), 0);
        checkOutput({pfx, "_alloc_ready"}, 32'(bus.alloc_ready), 1);
        checkOutput({pfx, "_alloc_tag"}, 32'(bus.alloc_tag), 0);
    endtask

    // Scoreboard monitor: every presented commit must match the oldest
    // outstanding expected record.
    always @(negedge clk) begin : monitor
        commit_t e;
        if (rst_n && bus.commit_valid) begin
            if (expQ.size() == 0) begin
                numChecks++;
                numFails++;
                $display("[TB] FAIL unexpected_commit: got pc 0x%0h, expected no commit", bus.commit_pc);
            end else begin
                e = expQ.pop_front();
                checkOutput("commit_pc", bus.commit_pc, e.pc);
                checkOutput("commit_rd_write", 32'(bus.commit_rd_write), 32'(e.rd_write));
                checkOutput("commit_p_old", 32'(bus.commit_rd_p_old), 32'(e.p_old));
                checkOutput("commit_p_new", 32'(bus.commit_rd_p_new), 32'(e.p_new));
            end
        end
    end

    // Global time limit so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected to finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios.
    initial begin
        setIdle();
        #3;
        checkResetOutputs("rst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] single allocation, writeback and commit timing");
        checkOutput("a_tag0", 32'(bus.alloc_tag), 0);
        doAlloc(32'h100, 1'b1, 6'd33, 6'd5, 1'b1);
        checkOutput("a_not_empty", 32'(bus.empty), 0);
        checkOutput("a_tag1", 32'(bus.alloc_tag), 1);
        doWb(4'd0);
        checkOutput("a_commit_not_early", 32'(bus.commit_valid), 0);
        doIdle();
        checkOutput("a_commit_on_time", 32'(bus.commit_valid), 1);
        doIdle();
        checkOutput("a_commit_one_cycle", 32'(bus.commit_valid), 0);
        checkOutput("a_empty_after", 32'(bus.empty), 1);

        $display("[TB] out-of-order writeback, in-order commit");
        doFlush();
        checkOutput("b_tag_after_flush", 32'(bus.alloc_tag), 0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("b_alloc_tag", 32'(bus.alloc_tag), i);
            doAlloc(32'h200 + 32'(4 * i), (i != 1), 6'(10 + i), 6'(1 + i), 1'b1);
        end
        doWb(4'd2);
        checkOutput("b_no_commit_wb2", 32'(bus.commit_valid), 0);
        doWb(4'd0);
        checkOutput("b_no_commit_wb0", 32'(bus.commit_valid), 0);
        doWb(4'd1);
        checkOutput("b_commit_tag0", 32'(bus.commit_valid), 1);
        doIdle();
        checkOutput("b_commit_tag1", 32'(bus.commit_valid), 1);
        doIdle();
        checkOutput("b_commit_tag2", 32'(bus.commit_valid), 1);
        doIdle();
        checkOutput("b_commit_done", 32'(bus.commit_valid), 0);
        checkOutput("b_empty", 32'(bus.empty), 1);

        $display("[TB] fill to full, drop overflow, wrap, no bypass");
        doFlush();
        for (int i = 0; i < DEPTH; i++) begin
            checkOutput("c_alloc_tag", 32'(bus.alloc_tag), i);
            doAlloc(32'h1000 + 32'(4 * i), i[0], 6'(16 + i), 6'(i), 1'b1);
        end
        checkOutput("c_full", 32'(bus.full), 1);
        checkOutput("c_alloc_ready", 32'(bus.alloc_ready), 0);
        checkOutput("c_not_empty", 32'(bus.empty), 0);
        doAlloc(32'hDEAD0, 1'b1, 6'd63, 6'd63, 1'b0);
        checkOutput("c_full_after_drop", 32'(bus.full), 1);
        checkOutput("c_tag_after_drop", 32'(bus.alloc_tag), 0);
        doWb(4'd0);
        checkOutput("c_no_commit_yet", 32'(bus.commit_valid), 0);
        doIdle();
        checkOutput("c_commit_tag0", 32'(bus.commit_valid), 1);
        checkOutput("c_not_full", 32'(bus.full), 0);
        checkOutput("c_ready_again", 32'(bus.alloc_ready), 1);
        checkOutput("c_wrapped_tag", 32'(bus.alloc_tag), 0);
        doAlloc(32'h2000, 1'b1, 6'd40, 6'd41, 1'b1);
        checkOutput("c_full_after_wrap", 32'(bus.full), 1);
        checkOutput("c_tag_after_wrap", 32'(bus.alloc_tag), 1);
        doWb(4'd1);
        checkOutput("c_full_before_commit", 32'(bus.full), 1);
        doAlloc(32'hBEEF0, 1'b1, 6'd7, 6'd8, 1'b0);
        checkOutput("c_commit_tag1", 32'(bus.commit_valid), 1);
        checkOutput("c_no_bypass_full", 32'(bus.full), 0);
        checkOutput("c_no_bypass_tag", 32'(bus.alloc_tag), 1);

        $display("[TB] flush with entries partly done");
        doFlush();
        for (int i = 0; i < 5; i++) begin
            doAlloc(32'h3000 + 32'(4 * i), 1'b1, 6'(20 + i), 6'(2 + i), 1'b1);
        end
        doWb(4'd1);
        doWb(4'd3);
        checkOutput("d_head_not_done", 32'(bus.commit_valid), 0);
        applyStimulus(1'b1, 32'hBAD0, 1'b1, 6'd1, 6'd1, 1'b1, 4'd2, 1'b1);
        expQ.delete();
        checkOutput("d_empty", 32'(bus.empty), 1);
        checkOutput("d_full", 32'(bus.full), 0);
        checkOutput("d_no_commit", 32'(bus.commit_valid), 0);
        checkOutput("d_tag0", 32'(bus.alloc_tag), 0);
        doIdle();
        checkOutput("d_still_no_commit", 32'(bus.commit_valid), 0);
        doAlloc(32'h300, 1'b1, 6'd50, 6'd51, 1'b1);
        checkOutput("d_tag1", 32'(bus.alloc_tag), 1);
        doAlloc(32'h304, 1'b0, 6'd52, 6'd53, 1'b1);
        doWb(4'd0);
        doIdle();
        checkOutput("d_commit_0x300", 32'(bus.commit_valid), 1);
        doIdle();
        checkOutput("d_done_cleared", 32'(bus.commit_valid), 0);
        doAllocWb(32'h308, 1'b1, 6'd54, 6'd55, 4'd1);
        checkOutput("d_aw_no_commit", 32'(bus.commit_valid), 0);
        checkOutput("d_aw_tag3", 32'(bus.alloc_tag), 3);
        doAllocWb(32'h30C, 1'b1, 6'd56, 6'd57, 4'd2);
        checkOutput("d_awc_commit", 32'(bus.commit_valid), 1);
        checkOutput("d_awc_tag4", 32'(bus.alloc_tag), 4);
        doWb(4'd3);
        checkOutput("d_commit_0x308", 32'(bus.commit_valid), 1);
        doIdle();
        checkOutput("d_commit_0x30c", 32'(bus.commit_valid), 1);
        doIdle();
        checkOutput("d_drained", 32'(bus.commit_valid), 0);
        checkOutput("d_empty_end", 32'(bus.empty), 1);

        $display("[TB] writeback to an invalid entry");
        doWb(4'd7);
        checkOutput("e_empty", 32'(bus.empty), 1);
        checkOutput("e_no_commit", 32'(bus.commit_valid), 0);
        checkOutput("e_tag_unchanged", 32'(bus.alloc_tag), 4);
        doIdle();
        checkOutput("e_no_commit_later", 32'(bus.commit_valid), 0);
        checkOutput("e_full", 32'(bus.full), 0);

        $display("[TB] asynchronous reset mid-flight");
        for (int i = 0; i < 4; i++) begin
            doAlloc(32'h500 + 32'(4 * i), 1'b1, 6'(44 + i), 6'(12 + i), 1'b1);
        end
        doWb(4'd4);
        doIdle();
        checkOutput("f_commit_before_reset", 32'(bus.commit_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkResetOutputs("f_async");
        expQ.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("f_resume_tag0", 32'(bus.alloc_tag), 0);
        doAlloc(32'h600, 1'b1, 6'd60, 6'd61, 1'b1);
        checkOutput("f_resume_tag1", 32'(bus.alloc_tag), 1);
        doWb(4'd0);
        doIdle();
        checkOutput("f_resume_commit", 32'(bus.commit_valid), 1);
        doIdle();
        checkOutput("f_resume_empty", 32'(bus.empty), 1);

        checkOutput("sb_drained", 32'(expQ.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
